alu_issue: RTL and testbench

Issue/decode front-end that drives the datapath's combinational 32-bit ALU as its initiator. It accepts one instruction word plus register operands over a valid/ready handshake and decodes the opcode/funct into the ALU's 3-bit op code and operand selection. It samples the ALU result and returns it with zero and illegal flags over a second valid/ready handshake. It sits between register read and writeback, and serves as the single point that maps ISA encodings onto ALU op codes.

---
 rtl/alu_issue.sv | 180 ++++++++++++++++++
 tb/tb_alu_issue.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Issue/decode front-end for the 32-bit combinational ALU: decodes one instruction
// per handshake into ALU operands/op, then captures and returns the ALU result.
module alu_issue (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_rs_val,
   input  logic [31:0] in_rt_val,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_op,
   input  logic [31:0] alu_out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_zero,
   output logic        out_illegal
);
   localparam int unsigned XLEN = 32;
   localparam int unsigned OPW  = 3;

   localparam logic [OPW-1:0] OP_ADD = 3'b000;
   localparam logic [OPW-1:0] OP_SUB = 3'b001;
   localparam logic [OPW-1:0] OP_AND = 3'b010;
   localparam logic [OPW-1:0] OP_OR  = 3'b011;
   localparam logic [OPW-1:0] OP_XOR = 3'b100;
   localparam logic [OPW-1:0] OP_SLL = 3'b101;
   localparam logic [OPW-1:0] OP_SRL = 3'b110;
   localparam logic [OPW-1:0] OP_NOT = 3'b111;

   localparam logic [5:0] OPC_RTYPE = 6'b000000;
   localparam logic [5:0] OPC_BEQ   = 6'b000100;
   localparam logic [5:0] OPC_ADDI  = 6'b001000;
   localparam logic [5:0] OPC_ANDI  = 6'b001100;
   localparam logic [5:0] OPC_ORI   = 6'b001101;
   localparam logic [5:0] OPC_XORI  = 6'b001110;

   localparam logic [5:0] F_SLL = 6'b000000;
   localparam logic [5:0] F_SRL = 6'b000010;
   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_XOR = 6'b100110;
   localparam logic [5:0] F_NOT = 6'b100111;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [OPW-1:0]  alu_op_q, alu_op_d;
   logic            illegal_q, illegal_d;
   logic [XLEN-1:0] out_result_q, out_result_d;
   logic            out_zero_q, out_zero_d;
   logic            out_illegal_q, out_illegal_d;
   logic            in_ready_q, in_ready_d;
   logic            out_valid_q, out_valid_d;

   logic [5:0]      opcode, funct;
   logic [4:0]      shamt;
   logic [15:0]     imm;
   logic [XLEN-1:0] dec_a, dec_b;
   logic [OPW-1:0]  dec_op;
   logic            dec_illegal;
   logic            unused_reg_fields;

   assign opcode = in_instr[31:26];
   assign funct  = in_instr[5:0];
   assign shamt  = in_instr[10:6];
   assign imm    = in_instr[15:0];
   // Register specifiers arrive already resolved as in_rs_val/in_rt_val.
   assign unused_reg_fields = ^in_instr[25:16];

   // Instruction decode into ALU operands and op code
   always_comb begin
      dec_a       = in_rs_val;
      dec_b       = in_rt_val;
      dec_op      = OP_ADD;
      dec_illegal = 1'b0;
      case (opcode)
         OPC_RTYPE: begin
            case (funct)
               F_ADD: dec_op = OP_ADD;
               F_SUB: dec_op = OP_SUB;
               F_AND: dec_op = OP_AND;
               F_OR:  dec_op = OP_OR;
               F_XOR: dec_op = OP_XOR;
               F_SLL: begin dec_op = OP_SLL; dec_a = in_rt_val; dec_b = XLEN'(shamt); end
               F_SRL: begin dec_op = OP_SRL; dec_a = in_rt_val; dec_b = XLEN'(shamt); end
               F_NOT: begin dec_op = OP_NOT; dec_b = '0; end
               default: dec_illegal = 1'b1;
            endcase
         end
         OPC_ADDI: begin dec_op = OP_ADD; dec_b = {{16{imm[15]}}, imm}; end
         OPC_ANDI: begin dec_op = OP_AND; dec_b = XLEN'(imm); end
         OPC_ORI:  begin dec_op = OP_OR;  dec_b = XLEN'(imm); end
         OPC_XORI: begin dec_op = OP_XOR; dec_b = XLEN'(imm); end
         OPC_BEQ:  dec_op = OP_SUB;
         default:  dec_illegal = 1'b1;
      endcase
      if (dec_illegal) begin
         dec_a  = '0;
         dec_b  = '0;
         dec_op = OP_ADD;
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d       = state_q;
      alu_a_d       = alu_a_q;
      alu_b_d       = alu_b_q;
      alu_op_d      = alu_op_q;
      illegal_d     = illegal_q;
      out_result_d  = out_result_q;
      out_zero_d    = out_zero_q;
      out_illegal_d = out_illegal_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               state_d   = EXEC;
               alu_a_d   = dec_a;
               alu_b_d   = dec_b;
               alu_op_d  = dec_op;
               illegal_d = dec_illegal;
            end
         end
         EXEC: begin
            state_d       = RESP;
            out_result_d  = illegal_q ? '0 : alu_out;
            out_zero_d    = illegal_q || (alu_out == '0);
            out_illegal_d = illegal_q;
         end
         RESP: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == RESP);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         alu_op_q      <= OP_ADD;
         illegal_q     <= 1'b0;
         out_result_q  <= '0;
         out_zero_q    <= 1'b0;
         out_illegal_q <= 1'b0;
         in_ready_q    <= 1'b1;
         out_valid_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         alu_op_q      <= alu_op_d;
         illegal_q     <= illegal_d;
         out_result_q  <= out_result_d;
         out_zero_q    <= out_zero_d;
         out_illegal_q <= out_illegal_d;
         in_ready_q    <= in_ready_d;
         out_valid_q   <= out_valid_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_op      = alu_op_q;
   assign out_result  = out_result_q;
   assign out_zero    = out_zero_q;
   assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed vectors with hand-computed results,
// a behavioural ALU model on the alu_* side, and a handshake-driven monitor.
module tb_alu_issue;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr, in_rs_val, in_rt_val;
   logic [31:0] alu_a, alu_b, alu_out;
   logic [2:0]  alu_op;
   logic        out_valid, out_ready;
   logic [31:0] out_result;
   logic        out_zero, out_illegal;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] instr, rs, rt;
      logic [2:0]  op;
      logic [31:0] a, b, res;
      logic        zero, ill;
      int          stall;
   } vec_t;

   vec_t exp_q[$];
   vec_t vecs[15];

   alu_issue dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_zero(out_zero), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   // Datapath ALU the block drives
   always_comb begin
      case (alu_op)
         3'b000:  alu_out = alu_a + alu_b;
         3'b001:  alu_out = alu_a - alu_b;
         3'b010:  alu_out = alu_a & alu_b;
         3'b011:  alu_out = alu_a | alu_b;
         3'b100:  alu_out = alu_a ^ alu_b;
         3'b101:  alu_out = alu_a << alu_b;
         3'b110:  alu_out = alu_a >> alu_b;
         default: alu_out = ~alu_a;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops an expectation on every response handshake
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_response: got result %h with empty scoreboard", out_result);
         end else begin
            vec_t e;
            e = exp_q.pop_front();
            chk("out_result", out_result, e.res);
            chk("out_zero", 32'(out_zero), 32'(e.zero));
            chk("out_illegal", 32'(out_illegal), 32'(e.ill));
            chk("alu_op", 32'(alu_op), 32'(e.op));
            chk("alu_a", alu_a, e.a);
            chk("alu_b", alu_b, e.b);
         end
      end
   end

   task automatic send(input vec_t v);
      int n = 0;
      while (!in_ready && n < 50) begin tick(); n++; end
      chk("in_ready_wait", 32'(in_ready), 32'd1);
      in_valid  = 1'b1;
      in_instr  = v.instr;
      in_rs_val = v.rs;
      in_rt_val = v.rt;
      out_ready = (v.stall == 0);
      exp_q.push_back(v);
      tick();
      // Scramble operands after accept; the operation in flight must not see them
      in_valid  = 1'b0;
      in_instr  = 32'h0022_1820;
      in_rs_val = 32'h1357_9BDF;
      in_rt_val = 32'h2468_ACE0;
      tick();
      if (v.stall > 0) begin
         in_valid = 1'b1;
         for (int i = 0; i < v.stall; i++) begin
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_result", out_result, v.res);
            chk("stall_alu_op", 32'(alu_op), 32'(v.op));
            tick();
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end
      n = 0;
      while (out_valid && n < 50) begin tick(); n++; end
      chk("resp_drain", 32'(out_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{32'h00221822, 32'd10,        32'd3,         3'd1, 32'd10,        32'd3,         32'd7,         1'b0, 1'b0, 4};
      vecs[1]  = '{32'h2022FFFB, 32'd5,         32'h77,        3'd0, 32'd5,         32'hFFFFFFFB, 32'd0,         1'b1, 1'b0, 0};
      vecs[2]  = '{32'h000207C0, 32'h9999,      32'd1,         3'd5, 32'd1,         32'd31,        32'h80000000, 1'b0, 1'b0, 0};
      vecs[3]  = '{32'h34008000, 32'd0,         32'h55,        3'd3, 32'd0,         32'h8000,      32'h8000,      1'b0, 1'b0, 0};
      vecs[4]  = '{32'h10220000, 32'h1234,      32'h1234,      3'd1, 32'h1234,      32'h1234,      32'd0,         1'b1, 1'b0, 0};
      vecs[5]  = '{32'hFC000000, 32'hDEAD,      32'hBEEF,      3'd0, 32'd0,         32'd0,         32'd0,         1'b1, 1'b1, 0};
      vecs[6]  = '{32'h00221820, 32'hFFFFFFFF, 32'd1,         3'd0, 32'hFFFFFFFF, 32'd1,         32'd0,         1'b1, 1'b0, 0};
      vecs[7]  = '{32'h00221824, 32'hF0F0F0F0, 32'hFF00FF00, 3'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 0};
      vecs[8]  = '{32'h00221826, 32'hAAAA5555, 32'hFFFF0000, 3'd4, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1'b0, 2};
      vecs[9]  = '{32'h00020102, 32'd1,         32'h80000000, 3'd6, 32'h80000000, 32'd4,         32'h08000000, 1'b0, 1'b0, 0};
      vecs[10] = '{32'h00221827, 32'h0000FFFF, 32'd1,         3'd7, 32'h0000FFFF, 32'd0,         32'hFFFF0000, 1'b0, 1'b0, 0};
      vecs[11] = '{32'h30228001, 32'hFFFFFFFF, 32'd0,         3'd2, 32'hFFFFFFFF, 32'h8001,      32'h8001,      1'b0, 1'b0, 0};
      vecs[12] = '{32'h3822FFFF, 32'h0000FFFF, 32'd0,         3'd4, 32'h0000FFFF, 32'hFFFF,      32'd0,         1'b1, 1'b0, 0};
      vecs[13] = '{32'h00221801, 32'd5,         32'd6,         3'd0, 32'd0,         32'd0,         32'd0,         1'b1, 1'b1, 0};
      vecs[14] = '{32'h10220000, 32'd5,         32'd3,         3'd1, 32'd5,         32'd3,         32'd2,         1'b0, 1'b0, 0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_rs_val = '0;
      in_rt_val = '0;
      out_ready = 1'b1;
      repeat (2) tick();
      rst_n = 1'b1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_alu_op", 32'(alu_op), 32'd0);
      chk("rst_out_result", out_result, 32'd0);
      chk("rst_out_zero", 32'(out_zero), 32'd0);
      chk("rst_out_illegal", 32'(out_illegal), 32'd0);

      // in_valid pulses while not ready are covered by the stall vectors
      foreach (vecs[i]) send(vecs[i]);

      // Reset during EXEC aborts the add; no response may ever appear
      in_valid  = 1'b1;
      in_instr  = 32'h00221820;
      in_rs_val = 32'd1;
      in_rt_val = 32'd2;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_alu_op", 32'(alu_op), 32'd0);
      chk("abort_out_result", out_result, 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("abort_no_valid", 32'(out_valid), 32'd0);
         chk("abort_idle_ready", 32'(in_ready), 32'd1);
      end

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
